// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-lane, 4-bit TDM link (mux-side framer and demux-side receiver).
package tdm_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    localparam logic ST_HUNT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        S_HUNT = ST_HUNT,
        S_RUN  = ST_RUN
    } tdm_state_e;

    // Frame-error causes; the framer reports with the same codes.
    localparam logic [1:0] FERR_NONE        = 2'd0;
    localparam logic [1:0] FERR_EARLY_SOF   = 2'd1;
    localparam logic [1:0] FERR_MISSING_SOF = 2'd2;

    function automatic logic [SEL_W-1:0] slot_inc(input logic [SEL_W-1:0] slot);
        return slot + 2'd1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index within a TDM frame: clear dominates load-to-1, which dominates increment.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_load1,
    input  logic             i_clr,
    output logic [SEL_W-1:0] o_slot
);

    logic [SEL_W-1:0] r_slot;
    logic [SEL_W-1:0] w_slot_nxt;

    // Next-slot selection
    always_comb begin
        w_slot_nxt = r_slot;
        if (i_clr) begin
            w_slot_nxt = 2'd0;
        end else if (i_load1) begin
            w_slot_nxt = 2'd1;
        end else if (i_en) begin
            w_slot_nxt = slot_inc(r_slot);
        end else begin
            w_slot_nxt = r_slot;
        end
    end

    // Slot register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= 2'd0;
        end else begin
            r_slot <= w_slot_nxt;
        end
    end

    assign o_slot = r_slot;

endmodule

// File: rtl/tdm_demux_1to4_4b.sv
// TDM receiver: locks to SOF framing, collects four slot words and presents them as one
// registered parallel frame with a single-cycle out_valid pulse.
module tdm_demux_1to4_4b #(
    parameter int WIDTH = 4,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             out_valid,
    output logic             locked,
    output logic             frame_err
);
    import tdm_pkg::*;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LANES - 1);

    tdm_state_e       r_state;
    tdm_state_e       w_state_nxt;
    logic [SEL_W-1:0] w_slot;
    logic             w_cnt_en;
    logic             w_cnt_ld1;
    logic             w_cnt_clr;
    logic [2:0]       w_sh_we;
    logic             w_frame_done;
    logic [1:0]       w_err_cause;
    logic [WIDTH-1:0] r_shadow [0:2];

    tdm_slot_counter u_slot_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_cnt_en),
        .i_load1 (w_cnt_ld1),
        .i_clr   (w_cnt_clr),
        .o_slot  (w_slot)
    );

    // Framing FSM: next state, slot-counter controls, shadow write enables, frame/error events
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_en     = 1'b0;
        w_cnt_ld1    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_sh_we      = 3'b000;
        w_frame_done = 1'b0;
        w_err_cause  = FERR_NONE;
        case (r_state)
            S_HUNT: begin
                if (in_valid && in_sof) begin
                    w_cnt_ld1   = 1'b1;
                    w_sh_we     = 3'b001;
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_clr   = 1'b1;
                end
            end
            S_RUN: begin
                if (!in_valid) begin
                    w_state_nxt = r_state;
                end else if (in_sof) begin
                    // An SOF anywhere restarts the frame; mid-frame it also aborts the partial one.
                    w_cnt_ld1 = 1'b1;
                    w_sh_we   = 3'b001;
                    if (w_slot != 2'd0) begin
                        w_err_cause = FERR_EARLY_SOF;
                    end else begin
                        w_err_cause = FERR_NONE;
                    end
                end else if (w_slot == 2'd0) begin
                    w_err_cause = FERR_MISSING_SOF;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_HUNT;
                end else if (w_slot == LAST_SLOT) begin
                    w_frame_done = 1'b1;
                    w_cnt_en     = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                    w_sh_we  = 3'b001 << w_slot;
                end
            end
            default: begin
                w_state_nxt = S_HUNT;
                w_cnt_clr   = 1'b1;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shadow registers for slots 0..2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_sh_we[i]) begin
                    r_shadow[i] <= in_data;
                end
            end
        end
    end

    // Output registers: lanes only change on a completed frame; pulses last one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= w_frame_done;
            frame_err <= (w_err_cause != FERR_NONE);
            if (w_frame_done) begin
                out0 <= r_shadow[0];
                out1 <= r_shadow[1];
                out2 <= r_shadow[2];
                out3 <= in_data;
            end
        end
    end

    assign locked = (r_state == S_RUN);

endmodule

// File: tb/tb_tdm_demux_1to4_4b.sv
// Randomized and directed bench for tdm_demux_1to4_4b against a queue-based frame model.
module tb_tdm_demux_1to4_4b;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_sof;
    logic [3:0] in_data;
    logic [3:0] out0, out1, out2, out3;
    logic       out_valid;
    logic       locked;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    // Reference model: locked flag plus the words of the frame collected so far.
    bit         m_locked;
    logic [3:0] m_q[$];
    logic [15:0] m_out;
    bit         m_valid;
    bit         m_err;

    tdm_demux_1to4_4b #(.WIDTH(4), .LANES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .locked    (locked),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_q.delete();
        m_out   = 16'h0000;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_word(input bit sof, input logic [3:0] d);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!m_locked) begin
            if (sof) begin
                m_locked = 1'b1;
                m_q = {d};
            end
        end else if (sof) begin
            if (m_q.size() != 0) m_err = 1'b1;
            m_q = {d};
        end else if (m_q.size() == 0) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
        end else begin
            m_q.push_back(d);
            if (m_q.size() == 4) begin
                m_out   = {m_q[3], m_q[2], m_q[1], m_q[0]};
                m_valid = 1'b1;
                m_q.delete();
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".outs"},   {16'h0000, out3, out2, out1, out0}, {16'h0000, m_out});
        chk({tag, ".valid"},  {31'd0, out_valid}, {31'd0, m_valid});
        chk({tag, ".err"},    {31'd0, frame_err}, {31'd0, m_err});
        chk({tag, ".locked"}, {31'd0, locked},    {31'd0, m_locked});
    endtask

    task automatic step(input string tag, input bit v, input bit sof, input logic [3:0] d);
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        if (v) begin
            model_word(sof, d);
        end else begin
            m_valid = 1'b0;
            m_err   = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse applied between clock edges.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 4'h0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Clean frame, continuous valid
        step("clean0", 1'b1, 1'b1, 4'h1);
        step("clean1", 1'b1, 1'b0, 4'h2);
        step("clean2", 1'b1, 1'b0, 4'h4);
        step("clean3", 1'b1, 1'b0, 4'h6);
        step("clean_idle", 1'b0, 1'b0, 4'hF);

        // Same frame with bubbles between slots
        step("gap0", 1'b1, 1'b1, 4'h1);
        step("gapi0", 1'b0, 1'b1, 4'h9);
        step("gap1", 1'b1, 1'b0, 4'h2);
        step("gapi1", 1'b0, 1'b0, 4'hA);
        step("gap2", 1'b1, 1'b0, 4'h4);
        step("gapi2", 1'b0, 1'b1, 4'hB);
        step("gap3", 1'b1, 1'b0, 4'h6);
        step("gapi3", 1'b0, 1'b0, 4'hC);

        // Non-SOF words while hunting
        async_reset("rst_hunt");
        step("hunt0", 1'b1, 1'b0, 4'h5);
        step("hunt1", 1'b1, 1'b0, 4'h7);
        step("hunt2", 1'b0, 1'b1, 4'h8);

        // Early SOF aborts the partial frame
        step("early0", 1'b1, 1'b1, 4'h1);
        step("early1", 1'b1, 1'b0, 4'h2);
        step("early2", 1'b1, 1'b1, 4'h3);
        step("early3", 1'b1, 1'b0, 4'h4);
        step("early4", 1'b1, 1'b0, 4'h5);
        step("early5", 1'b1, 1'b0, 4'h7);

        // Missing SOF after a good frame
        step("miss0", 1'b1, 1'b0, 4'hE);
        step("miss1", 1'b1, 1'b0, 4'hD);
        step("miss2", 1'b1, 1'b0, 4'hC);

        // Reset in mid-frame, then leftover words must not produce a frame
        step("mid0", 1'b1, 1'b1, 4'h9);
        step("mid1", 1'b1, 1'b0, 4'hA);
        step("mid2", 1'b1, 1'b0, 4'hB);
        async_reset("rst_mid");
        step("mid3", 1'b1, 1'b0, 4'hC);
        step("mid4", 1'b1, 1'b0, 4'hD);
        step("mid5", 1'b1, 1'b0, 4'hE);
        step("mid6", 1'b1, 1'b0, 4'hF);

        // Randomized traffic: mostly well-formed frames with occasional framing faults
        k = 0;
        for (int n = 0; n < 3000; n++) begin
            bit v, sof;
            v = ($urandom_range(0, 4) != 0);
            sof = ((k % 4) == 0) ^ ($urandom_range(0, 15) == 0);
            step("rand", v, sof, 4'($urandom_range(0, 15)));
            if (v) k++;
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rand_rst");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1to4_4b.md
# tdm_demux_1to4_4b

Receive-side counterpart of the 4-to-1 4-bit multiplexer. The multiplexer side sends four lanes as a time-division stream of 4-bit words, with a start-of-frame marker on lane 0. This block locks onto that framing, collects one word per slot, and presents all four lanes at once as registered outputs with a one-cycle frame-valid pulse. It sits directly after the TDM link, in front of lane consumers that expect parallel 4-bit data.

## Interface
Parameters:
- WIDTH, 4, data word width per lane.
- LANES, 4, slots per frame; fixed at 4 (slot index is 2 bits).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data/in_sof are meaningful this cycle.
- in_sof  in  1  marks the slot-0 word of a frame; qualified by in_valid.
- in_data  in  WIDTH  incoming slot word.
- out0, out1, out2, out3  out  WIDTH each  lane words of the last complete frame.
- out_valid  out  1  one-cycle pulse: out0..out3 were just updated.
- locked  out  1  high while in RUN state.
- frame_err  out  1  one-cycle pulse on a framing violation.

## Operation
- FSM with two states:
  - HUNT: the reset state.
  - RUN: frame alignment is held.
- Internal slot counter (2 bits) and three shadow registers for slots 0–2.
- An input word is "accepted" only on a cycle with in_valid=1. Cycles with in_valid=0 change nothing: the slot does not advance and no pulses are produced.
- HUNT:
  - Accepted words with in_sof=0 are discarded silently, with no frame_err.
  - An accepted word with in_sof=1 is stored in shadow[0]; slot becomes 1 and the FSM moves to RUN.
- RUN, accepted word at slot s:
  - s=0, in_sof=1: store in shadow[0]; slot becomes 1.
  - s=0, in_sof=0: pulse frame_err, discard the word, go to HUNT.
  - s=1 or 2, in_sof=0: store in shadow[s]; slot becomes s+1.
  - s=3, in_sof=0: out0..out2 take shadow[0..2], out3 takes in_data, out_valid pulses, and slot wraps to 0.
  - s=1..3, in_sof=1 (early SOF): pulse frame_err and discard the partial frame. The word is treated as a new slot 0: stored in shadow[0], slot becomes 1, and the FSM stays in RUN.
- Outputs out0..out3 hold their value until the next complete frame. A partial or aborted frame never changes them.
- locked = (state == RUN).

## Timing
- All state, counter, shadow and output registers update on the rising edge of clk.
- Reset values:
  - state=HUNT, slot=0, shadows=0.
  - out0..out3=0, out_valid=0, locked=0, frame_err=0.
- Reset is asserted asynchronously, and deassertion takes effect at the next clk edge.
- Reset in the middle of a frame discards the frame. The block must then see a fresh SOF before it produces output.
- Latency:
  - out0..out3 and out_valid become visible one cycle after the edge at which the slot-3 word is sampled.
  - frame_err is visible one cycle after the offending word is sampled.
- Throughput: with continuous in_valid, out_valid pulses once every 4 cycles and there are no bubbles between back-to-back frames.
- out_valid and frame_err are never high in the same cycle.
- in_sof with in_valid=0 is ignored.

## Structure
- Shared package tdm_pkg holds:
  - LANES and SEL_W=2.
  - State encoding localparams ST_HUNT=1'b0 and ST_RUN=1'b1.
  - The frame-error cause constants, shared with the multiplexer-side framer.
- One sub-module, tdm_slot_counter: a 2-bit counter with enable (accepted word), synchronous load-to-1 (SOF), clear (abort/HUNT), and asynchronous rst_n.
- FSM, shadow registers and output registers stay in the top module.

## Test plan
- Reset, then send a clean frame with in_valid=1: (sof=1, 0001), 0010, 0100, 0110 → one cycle later out0..out3 = 0001, 0010, 0100, 0110, out_valid=1 for exactly one cycle, locked=1 from the cycle after the SOF.
- Same frame with in_valid=0 gaps inserted between every slot → identical outputs, with out_valid only after the 4th accepted word.
- Words with sof=0 while in HUNT → no output change, no frame_err, locked stays 0.
- Early SOF: (sof=1, 0001), 0010, then (sof=1, 0011), 0100, 0101, 0111 → frame_err pulses once; out = 0011, 0100, 0101, 0111; the earlier partial frame never appears.
- Missing SOF at slot 0 after a good frame → frame_err pulse, locked drops to 0, outputs keep the previous frame's values.
- Assert rst_n low after slot 2 of a frame → all outputs reset to 0 immediately. After release, slot-3 data plus further non-SOF words produce no out_valid.
